// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO drain serializer.
// Optional prefetch path is enabled by defining FIFO_DRAIN_PREFETCH_EN.
package fifo_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int BYTE_W_DEF = 8;
  localparam int WORD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_drain_shifter.sv
// Shift register holding the word being emitted, plus the beat index
// and last-beat flag. A load restarts the index at the LSB beat.
module fifo_drain_shifter
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  output logic [BYTE_W-1:0] beat,
  output logic              at_last
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  byte_idx;

  // Load has priority; the FSM never requests both in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      byte_idx <= '0;
    end else if (load_en) begin
      shreg    <= load_data;
      byte_idx <= '0;
    end else if (shift_en) begin
      shreg    <= shreg >> BYTE_W;
      byte_idx <= byte_idx + 1'b1;
    end
  end

  assign beat    = shreg[BYTE_W-1:0];
  assign at_last = (byte_idx == LAST_IDX);

endmodule

// File: rtl/fifo_drain_serializer.sv
// Pops words from a registered-output FIFO and emits them LSB byte first
// on a valid/ready stream. Define FIFO_DRAIN_PREFETCH_EN for zero-bubble words.
module fifo_drain_serializer
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty_i,
  input  logic [DATA_W-1:0]     fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_valid_o,
  output logic [BYTE_W-1:0]     m_data_o,
  output logic                  m_last_o,
  input  logic                  m_ready_i,
  output logic                  busy_o,
  output logic [WORD_CNT_W-1:0] word_cnt_o
);

  state_t                state;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic                  xfer;
  logic                  last_xfer;
  logic                  shift_en;
  logic                  load_en;
  logic                  at_last;
  logic                  refill;
  logic [DATA_W-1:0]     load_data;
  logic [BYTE_W-1:0]     beat;

  assign xfer      = m_valid_o && m_ready_i;
  assign last_xfer = xfer && at_last;
  assign shift_en  = xfer && !at_last;

`ifdef FIFO_DRAIN_PREFETCH_EN
  logic [DATA_W-1:0] hold_data;
  logic              hold_vld;
  logic              pending;

  assign refill    = hold_vld || pending;
  assign load_data = (state == SEND && hold_vld) ? hold_data : fifo_data_i;
  assign busy_o    = (state != IDLE) || refill;

  // A pending read lands in the hold register unless the current word is
  // finishing in the same cycle, in which case it goes straight to the shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (fifo_rd_en_o && state == SEND && !last_xfer) begin
        pending <= 1'b1;
      end else if (pending) begin
        pending <= 1'b0;
        if (!last_xfer) begin
          hold_data <= fifo_data_i;
          hold_vld  <= 1'b1;
        end
      end
      if (hold_vld && last_xfer) begin
        hold_vld <= 1'b0;
      end
    end
  end
`else
  assign refill    = 1'b0;
  assign load_data = fifo_data_i;
  assign busy_o    = (state != IDLE);
`endif

  assign load_en = (state == LOAD) || (last_xfer && refill);

  // Pop requests never fire on an empty FIFO or while reset is held.
  always_comb begin
    fifo_rd_en_o = 1'b0;
    if (reset && !fifo_empty_i) begin
      if (state == IDLE) begin
        fifo_rd_en_o = 1'b1;
      end
`ifdef FIFO_DRAIN_PREFETCH_EN
      else if (state == SEND && !hold_vld && !pending) begin
        fifo_rd_en_o = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (fifo_rd_en_o) state <= LOAD;
        LOAD: state <= SEND;
        SEND: begin
          if (last_xfer) begin
            word_cnt <= word_cnt + 1'b1;
            if (!refill) begin
              state <= fifo_rd_en_o ? LOAD : IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_drain_shifter #(
    .DATA_W (DATA_W),
    .BYTE_W (BYTE_W)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_data (load_data),
    .shift_en  (shift_en),
    .beat      (beat),
    .at_last   (at_last)
  );

  assign m_valid_o  = (state == SEND);
  assign m_data_o   = m_valid_o ? beat : '0;
  assign m_last_o   = m_valid_o && at_last;
  assign word_cnt_o = word_cnt;

endmodule
